fp_divider: RTL and testbench

IEEE-754 single-precision divider (z = a / b) for the FPU path of the RISC-V pipeline core. It is the companion to the FP multiplier and uses the same strobe interface, so the execute stage drives both with identical sequencing. The divider is iterative: one quotient bit per clock, with round-to-nearest-even. Denormal inputs and outputs are handled in hardware.

---
 rtl/fp_divider.sv | 183 ++++++++++++++++++
 tb/tb_fp_divider.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/fp_divider.sv
// fp_divider: iterative IEEE-754 single-precision divider, one quotient bit per clock, round-to-nearest-even
module fp_divider #(
    parameter int ITER = 50
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] input_a,
    input  logic        input_a_stb,
    input  logic [31:0] input_b,
    input  logic        input_b_stb,
    output logic [31:0] output_z,
    output logic        output_z_stb,
    output logic        active
);
    typedef enum logic [3:0] {
        GET_A, GET_B, UNPACK, SPECIAL, NORM_A, NORM_B, DIV_0,
        DIV_1, DIV_2, NORM_1, NORM_2, ROUND, PACK, PUT_Z
    } state_t;

    state_t            state_q;
    logic [31:0]       a_q, b_q, z_q;
    logic [23:0]       a_m_q, b_m_q, z_m_q;
    logic signed [9:0] a_e_q, b_e_q, z_e_q;
    logic              a_s_q, b_s_q, z_s_q;
    logic              guard_q, round_q, sticky_q;
    logic [49:0]       dvd_q;
    logic [26:0]       quo_q;
    logic [24:0]       rem_q;
    logic [5:0]        cnt_q;
    logic [25:0]       rem_sh;
    logic              rem_ge, sgn;
    logic              a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;

    // The partial remainder never exceeds twice the divisor, so 25 bits plus the shifted-in bit suffice.
    assign rem_sh = {rem_q, dvd_q[49]};
    assign rem_ge = rem_sh >= {2'b00, b_m_q};
    assign sgn    = a_s_q ^ b_s_q;
    assign a_nan  = a_e_q == 10'sd128 && a_m_q[22:0] != 23'd0;
    assign b_nan  = b_e_q == 10'sd128 && b_m_q[22:0] != 23'd0;
    assign a_inf  = a_e_q == 10'sd128 && a_m_q[22:0] == 23'd0;
    assign b_inf  = b_e_q == 10'sd128 && b_m_q[22:0] == 23'd0;
    assign a_zero = a_e_q == -10'sd127 && a_m_q[22:0] == 23'd0;
    assign b_zero = b_e_q == -10'sd127 && b_m_q[22:0] == 23'd0;
    assign active = state_q != GET_A;

    // Control FSM and datapath: operand capture, special cases, long division, normalise, round, pack.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= GET_A;
            a_q          <= '0;
            b_q          <= '0;
            z_q          <= '0;
            a_m_q        <= '0;
            b_m_q        <= '0;
            z_m_q        <= '0;
            a_e_q        <= '0;
            b_e_q        <= '0;
            z_e_q        <= '0;
            a_s_q        <= 1'b0;
            b_s_q        <= 1'b0;
            z_s_q        <= 1'b0;
            guard_q      <= 1'b0;
            round_q      <= 1'b0;
            sticky_q     <= 1'b0;
            dvd_q        <= '0;
            quo_q        <= '0;
            rem_q        <= '0;
            cnt_q        <= '0;
            output_z     <= '0;
            output_z_stb <= 1'b0;
        end else begin
            output_z_stb <= 1'b0;
            case (state_q)
                GET_A: if (input_a_stb) begin
                    a_q     <= input_a;
                    state_q <= GET_B;
                end
                GET_B: if (input_b_stb) begin
                    b_q     <= input_b;
                    state_q <= UNPACK;
                end
                UNPACK: begin
                    a_m_q   <= {1'b0, a_q[22:0]};
                    b_m_q   <= {1'b0, b_q[22:0]};
                    a_e_q   <= $signed({2'b00, a_q[30:23]}) - 10'sd127;
                    b_e_q   <= $signed({2'b00, b_q[30:23]}) - 10'sd127;
                    a_s_q   <= a_q[31];
                    b_s_q   <= b_q[31];
                    state_q <= SPECIAL;
                end
                SPECIAL: begin
                    state_q <= PUT_Z;
                    if (a_nan || b_nan || (a_inf && b_inf) || (a_zero && b_zero)) begin
                        z_q <= 32'hFFC0_0000;
                    end else if (a_inf || b_zero) begin
                        z_q <= {sgn, 8'hFF, 23'd0};
                    end else if (b_inf || a_zero) begin
                        z_q <= {sgn, 31'd0};
                    end else begin
                        if (a_e_q == -10'sd127) a_e_q <= -10'sd126;
                        else a_m_q[23] <= 1'b1;
                        if (b_e_q == -10'sd127) b_e_q <= -10'sd126;
                        else b_m_q[23] <= 1'b1;
                        state_q <= NORM_A;
                    end
                end
                NORM_A: if (a_m_q[23]) begin
                    state_q <= NORM_B;
                end else begin
                    a_m_q <= {a_m_q[22:0], 1'b0};
                    a_e_q <= a_e_q - 10'sd1;
                end
                NORM_B: if (b_m_q[23]) begin
                    state_q <= DIV_0;
                end else begin
                    b_m_q <= {b_m_q[22:0], 1'b0};
                    b_e_q <= b_e_q - 10'sd1;
                end
                DIV_0: begin
                    z_s_q   <= sgn;
                    z_e_q   <= a_e_q - b_e_q;
                    dvd_q   <= {a_m_q, 26'd0};
                    quo_q   <= '0;
                    rem_q   <= '0;
                    cnt_q   <= '0;
                    state_q <= DIV_1;
                end
                DIV_1: begin
                    quo_q <= {quo_q[25:0], rem_ge};
                    dvd_q <= {dvd_q[48:0], 1'b0};
                    rem_q <= rem_ge ? rem_sh[24:0] - {1'b0, b_m_q} : rem_sh[24:0];
                    cnt_q <= cnt_q + 6'd1;
                    if (cnt_q == 6'(ITER - 1)) state_q <= DIV_2;
                end
                DIV_2: begin
                    z_m_q    <= quo_q[26:3];
                    guard_q  <= quo_q[2];
                    round_q  <= quo_q[1];
                    sticky_q <= quo_q[0] | (rem_q != 25'd0);
                    state_q  <= NORM_1;
                end
                NORM_1: if (z_m_q[23]) begin
                    state_q <= NORM_2;
                end else begin
                    z_m_q   <= {z_m_q[22:0], guard_q};
                    guard_q <= round_q;
                    round_q <= 1'b0;
                    z_e_q   <= z_e_q - 10'sd1;
                end
                NORM_2: if (z_e_q < -10'sd126) begin
                    z_m_q    <= {1'b0, z_m_q[23:1]};
                    z_e_q    <= z_e_q + 10'sd1;
                    guard_q  <= z_m_q[0];
                    round_q  <= guard_q;
                    sticky_q <= sticky_q | round_q;
                end else begin
                    state_q <= ROUND;
                end
                ROUND: begin
                    if (guard_q && (round_q || sticky_q || z_m_q[0])) begin
                        z_m_q <= z_m_q + 24'd1;
                        if (z_m_q == 24'hFF_FFFF) begin
                            z_m_q <= 24'h80_0000;
                            z_e_q <= z_e_q + 10'sd1;
                        end
                    end
                    state_q <= PACK;
                end
                PACK: begin
                    z_q <= {z_s_q, (z_e_q == -10'sd126 && !z_m_q[23]) ? 8'd0 : z_e_q[7:0] + 8'd127, z_m_q[22:0]};
                    if (z_e_q > 10'sd127) z_q <= {z_s_q, 8'hFF, 23'd0};
                    state_q <= PUT_Z;
                end
                PUT_Z: begin
                    output_z     <= z_q;
                    output_z_stb <= 1'b1;
                    state_q      <= GET_A;
                end
                default: state_q <= GET_A;
            endcase
        end
    end
endmodule

// File: tb/tb_fp_divider.sv
// tb_fp_divider: directed vectors for fp_divider covering results, latency, handshake and reset
module tb_fp_divider;
    logic        clk;
    logic        rst;
    logic [31:0] input_a;
    logic        input_a_stb;
    logic [31:0] input_b;
    logic        input_b_stb;
    logic [31:0] output_z;
    logic        output_z_stb;
    logic        active;
    int          n_tests;
    int          n_fail;

    fp_divider #(.ITER(50)) dut (
        .clk         (clk),
        .rst         (rst),
        .input_a     (input_a),
        .input_a_stb (input_a_stb),
        .input_b     (input_b),
        .input_b_stb (input_b_stb),
        .output_z    (output_z),
        .output_z_stb(output_z_stb),
        .active      (active)
    );

    initial clk = 1'b0;
    // Free-running 10-unit clock.
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Both strobes raised together and held for two cycles; edge 1 captures a.
    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] z, input int lat);
        int   e;
        logic act_bad;
        logic [31:0] held;
        @(negedge clk);
        input_a     = a;
        input_b     = b;
        input_a_stb = 1'b1;
        input_b_stb = 1'b1;
        e           = 0;
        act_bad     = 1'b0;
        do begin
            @(posedge clk);
            #1;
            e++;
            if (e == 2) begin
                input_a_stb = 1'b0;
                input_b_stb = 1'b0;
            end
            if (output_z_stb ? active : !active) act_bad = 1'b1;
        end while (!output_z_stb && e < 300);
        held = output_z;
        check({tag, "_z"}, output_z, z);
        check({tag, "_lat"}, 32'(e), 32'(lat));
        check({tag, "_active"}, {31'd0, act_bad}, 32'd0);
        @(posedge clk);
        #1;
        check({tag, "_pulse"}, {31'd0, output_z_stb}, 32'd0);
        check({tag, "_hold"}, output_z, held);
    endtask

    initial begin
        int   e;
        int   hits[$];
        logic bad;
        n_tests     = 0;
        n_fail      = 0;
        rst         = 1'b0;
        input_a     = '0;
        input_b     = '0;
        input_a_stb = 1'b0;
        input_b_stb = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_z", output_z, 32'd0);
        check("rst_stb", {31'd0, output_z_stb}, 32'd0);
        check("rst_active", {31'd0, active}, 32'd0);
        @(negedge clk);
        rst = 1'b1;

        run_op("six_div_two", 32'h40C0_0000, 32'h4000_0000, 32'h4040_0000, 63);
        run_op("one_div_three", 32'h3F80_0000, 32'h4040_0000, 32'h3EAA_AAAB, 64);
        run_op("one_div_one", 32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000, 63);
        run_op("x_div_zero", 32'h3F80_0000, 32'h0000_0000, 32'h7F80_0000, 5);
        run_op("zero_div_zero", 32'h0000_0000, 32'h0000_0000, 32'hFFC0_0000, 5);
        run_op("x_div_inf", 32'hBF80_0000, 32'h7F80_0000, 32'h8000_0000, 5);
        run_op("nan_div_x", 32'h7FC0_0001, 32'h3F80_0000, 32'hFFC0_0000, 5);
        run_op("overflow", 32'h7F00_0000, 32'h3E80_0000, 32'h7F80_0000, 63);
        run_op("denorm_out", 32'h0080_0000, 32'h4000_0000, 32'h0040_0000, 64);
        run_op("denorm_in", 32'h0000_0001, 32'h3F80_0000, 32'h0000_0001, 109);

        // Divisor withheld for ten cycles after the dividend is accepted.
        @(negedge clk);
        input_a     = 32'h40C0_0000;
        input_b     = 32'h4000_0000;
        input_a_stb = 1'b1;
        @(posedge clk);
        #1;
        input_a_stb = 1'b0;
        bad         = 1'b0;
        repeat (10) begin
            @(posedge clk);
            #1;
            if (!active || output_z_stb) bad = 1'b1;
        end
        check("wait_b_idle", {31'd0, bad}, 32'd0);
        input_b_stb = 1'b1;
        e           = 1;
        do begin
            @(posedge clk);
            #1;
            e++;
            if (e == 2) input_b_stb = 1'b0;
        end while (!output_z_stb && e < 300);
        check("wait_b_z", output_z, 32'h4040_0000);
        check("wait_b_lat", 32'(e), 32'd63);

        // Strobes held high: back-to-back operations, each result a single-cycle pulse.
        @(negedge clk);
        input_a     = 32'h40C0_0000;
        input_b     = 32'h4000_0000;
        input_a_stb = 1'b1;
        input_b_stb = 1'b1;
        for (int i = 1; i <= 130; i++) begin
            @(posedge clk);
            #1;
            if (output_z_stb) hits.push_back(i);
        end
        input_a_stb = 1'b0;
        input_b_stb = 1'b0;
        check("b2b_count", 32'(hits.size()), 32'd2);
        check("b2b_first", 32'(hits[0]), 32'd63);
        check("b2b_second", 32'(hits[1]), 32'd126);
        check("b2b_z", output_z, 32'h4040_0000);

        // The third operation started at edge 127; reset it at its edge 30.
        repeat (26) @(posedge clk);
        #1;
        check("mid_active", {31'd0, active}, 32'd1);
        rst = 1'b0;
        #1;
        check("mid_rst_z", output_z, 32'd0);
        check("mid_rst_stb", {31'd0, output_z_stb}, 32'd0);
        check("mid_rst_active", {31'd0, active}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        run_op("after_rst", 32'h40C0_0000, 32'h4000_0000, 32'h4040_0000, 63);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
